// File: rtl/gpu_pkg.sv
// Shared encodings for the core pipeline: scheduler states, fetcher and LSU
// state constants, and the default program-memory address width.
package gpu_pkg;

    typedef enum logic [2:0] {
        CORE_IDLE    = 3'b000,
        CORE_FETCH   = 3'b001,
        CORE_DECODE  = 3'b010,
        CORE_REQUEST = 3'b011,
        CORE_WAIT    = 3'b100,
        CORE_EXECUTE = 3'b101,
        CORE_UPDATE  = 3'b110,
        CORE_DONE    = 3'b111
    } core_state_t;

    localparam logic [2:0] FETCHER_IDLE     = 3'b000;
    localparam logic [2:0] FETCHER_FETCHING = 3'b001;
    localparam logic [2:0] FETCHER_FETCHED  = 3'b010;

    localparam logic [1:0] LSU_IDLE       = 2'b00;
    localparam logic [1:0] LSU_REQUESTING = 2'b01;
    localparam logic [1:0] LSU_WAITING    = 2'b10;
    localparam logic [1:0] LSU_DONE       = 2'b11;

    localparam int PROGRAM_MEM_ADDR_BITS_DEFAULT = 8;

endpackage

// File: rtl/pc_select.sv
// Picks the block PC from the lowest-index enabled thread and flags any
// enabled thread whose next_pc disagrees with it.
module pc_select
    import gpu_pkg::*;
#(
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = PROGRAM_MEM_ADDR_BITS_DEFAULT
) (
    input  logic [THREADS_PER_BLOCK-1:0]                       thread_enable,
    input  logic [PROGRAM_MEM_ADDR_BITS*THREADS_PER_BLOCK-1:0] next_pc,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]                   selected_pc,
    output logic                                               mismatch
);

    logic found;

    always_comb begin
        selected_pc = '0;
        found       = 1'b0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (thread_enable[i] && !found) begin
                selected_pc = next_pc[i*PROGRAM_MEM_ADDR_BITS +: PROGRAM_MEM_ADDR_BITS];
                found       = 1'b1;
            end
        end
        mismatch = 1'b0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (thread_enable[i] &&
                next_pc[i*PROGRAM_MEM_ADDR_BITS +: PROGRAM_MEM_ADDR_BITS] != selected_pc) begin
                mismatch = 1'b1;
            end
        end
    end

endmodule

// File: rtl/core_scheduler.sv
// Per-core sequencer: walks FETCH..UPDATE, stalls on fetcher and enabled LSUs,
// owns current_pc, and records divergence and block completion.
module core_scheduler
    import gpu_pkg::*;
#(
    parameter int THREADS_PER_BLOCK     = 4,
    parameter int PROGRAM_MEM_ADDR_BITS = PROGRAM_MEM_ADDR_BITS_DEFAULT
) (
    input  logic                                               clk,
    input  logic                                               reset,
    input  logic                                               start,
    input  logic [THREADS_PER_BLOCK-1:0]                       thread_enable,
    input  logic [2:0]                                         fetcher_state,
    input  logic                                               decoded_mem_read_enable,
    input  logic                                               decoded_mem_write_enable,
    input  logic                                               decoded_ret,
    input  logic [2*THREADS_PER_BLOCK-1:0]                     lsu_state,
    input  logic [PROGRAM_MEM_ADDR_BITS*THREADS_PER_BLOCK-1:0] next_pc,
    output logic [2:0]                                         core_state,
    output logic [PROGRAM_MEM_ADDR_BITS-1:0]                   current_pc,
    output logic                                               done,
    output logic                                               pc_diverged
);

    core_state_t                      state_q, state_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] pc_q, pc_d;
    logic                             done_q, done_d;
    logic                             div_q, div_d;
    logic [PROGRAM_MEM_ADDR_BITS-1:0] selected_pc;
    logic                             mismatch;
    logic                             lsu_busy;

    pc_select #(
        .THREADS_PER_BLOCK    (THREADS_PER_BLOCK),
        .PROGRAM_MEM_ADDR_BITS(PROGRAM_MEM_ADDR_BITS)
    ) u_pc_select (
        .thread_enable(thread_enable),
        .next_pc      (next_pc),
        .selected_pc  (selected_pc),
        .mismatch     (mismatch)
    );

    // Only enabled threads can hold the core in WAIT.
    always_comb begin
        lsu_busy = 1'b0;
        for (int i = 0; i < THREADS_PER_BLOCK; i++) begin
            if (thread_enable[i] &&
                (lsu_state[2*i +: 2] == LSU_REQUESTING || lsu_state[2*i +: 2] == LSU_WAITING)) begin
                lsu_busy = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        done_d  = done_q;
        div_d   = div_q;
        case (state_q)
            CORE_IDLE: begin
                if (start) begin
                    if (thread_enable != '0) begin
                        state_d = CORE_FETCH;
                    end else begin
                        state_d = CORE_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            CORE_FETCH: begin
                if (fetcher_state == FETCHER_FETCHED) state_d = CORE_DECODE;
            end
            CORE_DECODE:  state_d = CORE_REQUEST;
            CORE_REQUEST: state_d = CORE_WAIT;
            CORE_WAIT: begin
                if (!(decoded_mem_read_enable || decoded_mem_write_enable) || !lsu_busy) begin
                    state_d = CORE_EXECUTE;
                end
            end
            CORE_EXECUTE: state_d = CORE_UPDATE;
            CORE_UPDATE: begin
                if (decoded_ret) begin
                    state_d = CORE_DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = CORE_FETCH;
                    pc_d    = selected_pc;
                    div_d   = div_q | mismatch;
                end
            end
            CORE_DONE: state_d = CORE_DONE;
            default:   state_d = CORE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= CORE_IDLE;
            pc_q    <= '0;
            done_q  <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            done_q  <= done_d;
            div_q   <= div_d;
        end
    end

    assign core_state  = state_q;
    assign current_pc  = pc_q;
    assign done        = done_q;
    assign pc_diverged = div_q;

endmodule

// File: tb/tb_core_scheduler.sv
// Directed bench for core_scheduler: a driver pushes the expected visible
// outputs each cycle and a negedge monitor pops and compares them.
module tb_core_scheduler;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_REQUEST = 3'd3;
    localparam logic [2:0] S_WAIT = 3'd4, S_EXECUTE = 3'd5, S_UPDATE = 3'd6, S_DONE = 3'd7;
    localparam int W = 13;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  thread_enable;
    logic [2:0]  fetcher_state;
    logic        decoded_mem_read_enable;
    logic        decoded_mem_write_enable;
    logic        decoded_ret;
    logic [7:0]  lsu_state;
    logic [31:0] next_pc;
    logic [2:0]  core_state;
    logic [7:0]  current_pc;
    logic        done;
    logic        pc_diverged;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks = 0;
    int           errors = 0;

    core_scheduler dut (
        .clk                     (clk),
        .reset                   (reset),
        .start                   (start),
        .thread_enable           (thread_enable),
        .fetcher_state           (fetcher_state),
        .decoded_mem_read_enable (decoded_mem_read_enable),
        .decoded_mem_write_enable(decoded_mem_write_enable),
        .decoded_ret             (decoded_ret),
        .lsu_state               (lsu_state),
        .next_pc                 (next_pc),
        .core_state              (core_state),
        .current_pc              (current_pc),
        .done                    (done),
        .pc_diverged             (pc_diverged)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input logic [2:0] st, input logic [7:0] pc, input logic dn,
                              input logic dv, input string nm);
        exp_q.push_back({st, pc, dn, dv});
        name_q.push_back(nm);
    endtask

    // Call with FETCHED presented and the core visibly in FETCH at pc_now.
    task automatic run_instr(input logic mem, input logic ret, input logic [7:0] busy_vec,
                             input int n_busy, input logic [7:0] final_vec,
                             input logic [7:0] pc_now, input logic div_now);
        decoded_mem_read_enable = mem;
        decoded_ret             = ret;
        expect_out(S_FETCH, pc_now, 1'b0, div_now, "fetch");     tick();
        expect_out(S_DECODE, pc_now, 1'b0, div_now, "decode");   tick();
        expect_out(S_REQUEST, pc_now, 1'b0, div_now, "request"); tick();
        for (int i = 0; i < n_busy; i++) begin
            lsu_state = busy_vec;
            expect_out(S_WAIT, pc_now, 1'b0, div_now, "wait_stall");
            tick();
        end
        lsu_state = final_vec;
        expect_out(S_WAIT, pc_now, 1'b0, div_now, "wait_last");  tick();
        expect_out(S_EXECUTE, pc_now, 1'b0, div_now, "execute"); tick();
        expect_out(S_UPDATE, pc_now, 1'b0, div_now, "update");   tick();
        decoded_mem_read_enable = 1'b0;
        decoded_ret             = 1'b0;
        lsu_state               = 8'hFF;
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        logic [W-1:0] a;
        string        nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            a  = {core_state, current_pc, done, pc_diverged};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s @%0t: got state=%0d pc=%h done=%b div=%b, expected state=%0d pc=%h done=%b div=%b",
                         nm, $time, a[12:10], a[9:2], a[1], a[0], e[12:10], e[9:2], e[1], e[0]);
            end
        end
    end

    initial begin
        reset = 1'b1;
        start = 1'b0;
        thread_enable = 4'b1111;
        fetcher_state = 3'b000;
        decoded_mem_read_enable = 1'b0;
        decoded_mem_write_enable = 1'b0;
        decoded_ret = 1'b0;
        lsu_state = 8'hFF;
        next_pc = 32'h01010101;
        #2 reset = 1'b0;
        tick();
        expect_out(S_IDLE, 8'h00, 1'b0, 1'b0, "reset_state"); tick();
        reset = 1'b1;
        expect_out(S_IDLE, 8'h00, 1'b0, 1'b0, "idle_no_start"); tick();

        // Basic pass, with the fetcher two cycles late.
        start = 1'b1;
        fetcher_state = 3'b001;
        expect_out(S_IDLE, 8'h00, 1'b0, 1'b0, "start_sampled"); tick();
        start = 1'b0;
        expect_out(S_FETCH, 8'h00, 1'b0, 1'b0, "fetch_stall0"); tick();
        expect_out(S_FETCH, 8'h00, 1'b0, 1'b0, "fetch_stall1"); tick();
        fetcher_state = 3'b010;
        run_instr(1'b0, 1'b0, 8'hFF, 0, 8'hFF, 8'h00, 1'b0);

        // LDR: thread 2 WAITING for 5 cycles.
        next_pc = 32'h02020202;
        run_instr(1'b1, 1'b0, 8'hEF, 5, 8'hFF, 8'h01, 1'b0);

        // Thread 2 disabled: its WAITING LSU must not stall.
        thread_enable = 4'b1011;
        next_pc = 32'h03030303;
        run_instr(1'b1, 1'b0, 8'hEF, 0, 8'hEF, 8'h02, 1'b0);

        // Disabled thread 0 ignored for selection and divergence.
        thread_enable = 4'b1110;
        next_pc = 32'h05050533;
        run_instr(1'b0, 1'b0, 8'hFF, 0, 8'hFF, 8'h03, 1'b0);
        next_pc = 32'h06050533;
        run_instr(1'b0, 1'b0, 8'hFF, 0, 8'hFF, 8'h05, 1'b0);

        // Sticky divergence, then wrap FF -> 00.
        thread_enable = 4'b1111;
        next_pc = 32'hFFFFFFFF;
        run_instr(1'b0, 1'b0, 8'hFF, 0, 8'hFF, 8'h05, 1'b1);
        next_pc = 32'h00000000;
        run_instr(1'b0, 1'b0, 8'hFF, 0, 8'hFF, 8'hFF, 1'b1);

        // RET terminates; pc held; start ignored.
        next_pc = 32'h07070707;
        run_instr(1'b0, 1'b1, 8'hFF, 0, 8'hFF, 8'h00, 1'b1);
        start = 1'b1;
        expect_out(S_DONE, 8'h00, 1'b1, 1'b1, "done_after_ret"); tick();
        start = 1'b0;
        expect_out(S_DONE, 8'h00, 1'b1, 1'b1, "done_start_ignored"); tick();

        // Fresh block, one instruction, then async reset in the middle of WAIT.
        reset = 1'b0;
        #1;
        expect_out(S_IDLE, 8'h00, 1'b0, 1'b0, "reset_from_done"); tick();
        reset = 1'b1;
        start = 1'b1;
        next_pc = 32'h44444444;
        expect_out(S_IDLE, 8'h00, 1'b0, 1'b0, "restart"); tick();
        start = 1'b0;
        run_instr(1'b0, 1'b0, 8'hFF, 0, 8'hFF, 8'h00, 1'b0);
        decoded_mem_read_enable = 1'b1;
        lsu_state = 8'hEF;
        expect_out(S_FETCH, 8'h44, 1'b0, 1'b0, "fetch_pc44"); tick();
        expect_out(S_DECODE, 8'h44, 1'b0, 1'b0, "decode_pc44"); tick();
        expect_out(S_REQUEST, 8'h44, 1'b0, 1'b0, "request_pc44"); tick();
        expect_out(S_WAIT, 8'h44, 1'b0, 1'b0, "wait_pc44"); tick();
        reset = 1'b0;
        #1;
        expect_out(S_IDLE, 8'h00, 1'b0, 1'b0, "async_reset_mid_wait"); tick();
        reset = 1'b1;
        decoded_mem_read_enable = 1'b0;
        lsu_state = 8'hFF;
        expect_out(S_IDLE, 8'h00, 1'b0, 1'b0, "idle_after_reset"); tick();

        // start with no enabled threads goes straight to DONE.
        thread_enable = 4'b0000;
        start = 1'b1;
        expect_out(S_IDLE, 8'h00, 1'b0, 1'b0, "start_no_threads"); tick();
        start = 1'b0;
        expect_out(S_DONE, 8'h00, 1'b1, 1'b0, "done_no_threads"); tick();

        repeat (2) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
